// File: rtl/multi_port_mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multi_port_mem_arbiter_pkg: shared types for the multi-client memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package multi_port_mem_arbiter_pkg;

  typedef logic [15:0] lc3b_word;

  localparam int ARB_MAX_CLIENTS = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  // Width of a client index; never zero so single-bit pointers stay legal.
  function automatic int idxWidth(input int nClient);
    return (nClient > 1) ? $clog2(nClient) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_port_mem_arbiter_rr_priority_picker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_priority_picker: combinational round-robin / fixed-priority selector
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_priority_picker
  import multi_port_mem_arbiter_pkg::*;
#(
  parameter int NCLIENT = 2,
  parameter int RR_MODE = 1,
  localparam int IW     = idxWidth(NCLIENT)
) (
  input  logic [NCLIENT-1:0] iReq,
  input  logic [IW-1:0]      iPtr,
  output logic               oValid,
  output logic [NCLIENT-1:0] oGrant,
  output logic [IW-1:0]      oIdx
);

  logic [IW-1:0] w_scanBase;
  logic          w_hiFound;
  logic [IW-1:0] w_hiIdx;
  logic [IW-1:0] w_loIdx;

  // Fixed priority is round-robin with the scan always starting at client 0.
  assign w_scanBase = (RR_MODE != 0) ? iPtr : '0;

  // Descending scan: the last hit written is the lowest index, both for the
  // "at or above base" set and for the wrap-around set.
  always_comb begin
    w_hiFound = 1'b0;
    w_hiIdx   = '0;
    w_loIdx   = '0;
    for (int k = NCLIENT - 1; k >= 0; k--) begin
      if (iReq[k]) begin
        w_loIdx = IW'(k);
        if (k >= int'(w_scanBase)) begin
          w_hiFound = 1'b1;
          w_hiIdx   = IW'(k);
        end
      end
    end
  end

  assign oValid = |iReq;
  assign oIdx   = w_hiFound ? w_hiIdx : w_loIdx;

  always_comb begin
    oGrant = '0;
    for (int k = 0; k < NCLIENT; k++) begin
      oGrant[k] = oValid && (oIdx == IW'(k));
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_port_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multi_port_mem_arbiter: NCLIENT cache-line clients onto one memory port
// Rev 1.0
// ----------------------------------------------------------------------------
module multi_port_mem_arbiter
  import multi_port_mem_arbiter_pkg::*;
#(
  parameter int NCLIENT = 2,
  parameter int n       = 128,
  parameter int ADDR_W  = 16,
  parameter int RR_MODE = 1
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [NCLIENT-1:0]      iReqRead,
  input  logic [NCLIENT-1:0]      iReqWrite,
  input  logic [NCLIENT*ADDR_W-1:0] iReqAddr,
  input  logic [NCLIENT*n-1:0]    iReqWData,
  input  logic                    iMemResp,
  input  logic [n-1:0]            iMemRData,
  output logic                    oMemRead,
  output logic                    oMemWrite,
  output logic [ADDR_W-1:0]       oMemAddr,
  output logic [n-1:0]            oMemWData,
  output logic [NCLIENT-1:0]      oResp,
  output logic [n-1:0]            oRData,
  output logic [NCLIENT-1:0]      oGrant
);

  localparam int IW = idxWidth(NCLIENT);

  arb_state_t        r_state;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_gIdx;

  logic [NCLIENT-1:0] w_req;
  logic               w_pickValid;
  logic [NCLIENT-1:0] w_pickGrant;
  logic [IW-1:0]      w_pickIdx;
  logic [ADDR_W-1:0]  w_selAddr;
  logic [n-1:0]       w_selWData;
  logic               w_selWrite;
  logic [IW-1:0]      w_nextPtr;

  assign w_req = iReqRead | iReqWrite;

  rr_priority_picker #(
    .NCLIENT (NCLIENT),
    .RR_MODE (RR_MODE)
  ) u_picker (
    .iReq   (w_req),
    .iPtr   (r_ptr),
    .oValid (w_pickValid),
    .oGrant (w_pickGrant),
    .oIdx   (w_pickIdx)
  );

  // Winner's operands; write wins when a client raises both strobes.
  always_comb begin
    w_selAddr  = '0;
    w_selWData = '0;
    w_selWrite = 1'b0;
    for (int k = 0; k < NCLIENT; k++) begin
      if (w_pickIdx == IW'(k)) begin
        w_selAddr  = iReqAddr[k*ADDR_W +: ADDR_W];
        w_selWData = iReqWData[k*n +: n];
        w_selWrite = iReqWrite[k];
      end
    end
  end

  // Explicit wrap so non-power-of-two client counts never reach an empty slot.
  assign w_nextPtr = (r_gIdx == IW'(NCLIENT - 1)) ? '0 : r_gIdx + IW'(1);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_gIdx    <= '0;
      oGrant    <= '0;
      oMemRead  <= 1'b0;
      oMemWrite <= 1'b0;
      oMemAddr  <= '0;
      oMemWData <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pickValid) begin
            r_gIdx    <= w_pickIdx;
            oGrant    <= w_pickGrant;
            oMemAddr  <= w_selAddr;
            oMemWData <= w_selWData;
            oMemWrite <= w_selWrite;
            oMemRead  <= ~w_selWrite;
            r_state   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (iMemResp) begin
            oMemRead  <= 1'b0;
            oMemWrite <= 1'b0;
            oGrant    <= '0;
            r_ptr     <= w_nextPtr;
            r_state   <= ARB_DONE;
          end
        end
        ARB_DONE: r_state <= ARB_IDLE;
        default:  r_state <= ARB_IDLE;
      endcase
    end
  end

  // oGrant is one-hot throughout BUSY, so it doubles as the response mask.
  assign oResp  = (r_state == ARB_BUSY && iMemResp) ? oGrant : '0;
  assign oRData = iMemRData;

  a_noReadWrite: assert property (@(posedge iClk) disable iff (iRst)
    (iReqRead & iReqWrite) == '0);
  a_respOneHot: assert property (@(posedge iClk) disable iff (iRst)
    $onehot0(oResp));

endmodule
`default_nettype wire

// File: tb/tb_multi_port_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_multi_port_mem_arbiter: scoreboard bench for two arbiter configurations
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_multi_port_mem_arbiter;

  localparam int LAT = 3;

  typedef struct {
    logic [2:0]   resp;
    logic [15:0]  addr;
    logic         wr;
    logic [127:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Two-client round-robin instance
  logic [1:0]   reqRead2, reqWrite2;
  logic [31:0]  reqAddr2;
  logic [255:0] reqWData2;
  wire          memResp2;
  wire  [127:0] memRData2;
  logic         memRead2, memWrite2;
  logic [15:0]  memAddr2;
  logic [127:0] memWData2, rData2;
  logic [1:0]   resp2, grant2;
  logic         autoResp2, manResp2, autoEn2;
  int           cnt2;

  // Three-client fixed-priority instance
  logic [2:0]   reqRead3, reqWrite3;
  logic [47:0]  reqAddr3;
  logic [383:0] reqWData3;
  wire          memResp3;
  wire  [127:0] memRData3;
  logic         memRead3, memWrite3;
  logic [15:0]  memAddr3;
  logic [127:0] memWData3, rData3;
  logic [2:0]   resp3, grant3;
  logic         autoResp3;
  int           cnt3;

  exp_t q2[$];
  exp_t q3[$];
  exp_t e2, e3;

  function automatic logic [127:0] rdataOf(input logic [15:0] a);
    return {8{a ^ 16'h5A5A}};
  endfunction

  assign memResp2  = autoResp2 | manResp2;
  assign memRData2 = rdataOf(memAddr2);
  assign memResp3  = autoResp3;
  assign memRData3 = rdataOf(memAddr3);

  multi_port_mem_arbiter #(.NCLIENT(2), .n(128), .ADDR_W(16), .RR_MODE(1)) dut2 (
    .iClk(clk), .iRst(rst), .iReqRead(reqRead2), .iReqWrite(reqWrite2),
    .iReqAddr(reqAddr2), .iReqWData(reqWData2), .iMemResp(memResp2), .iMemRData(memRData2),
    .oMemRead(memRead2), .oMemWrite(memWrite2), .oMemAddr(memAddr2), .oMemWData(memWData2),
    .oResp(resp2), .oRData(rData2), .oGrant(grant2)
  );

  multi_port_mem_arbiter #(.NCLIENT(3), .n(128), .ADDR_W(16), .RR_MODE(0)) dut3 (
    .iClk(clk), .iRst(rst), .iReqRead(reqRead3), .iReqWrite(reqWrite3),
    .iReqAddr(reqAddr3), .iReqWData(reqWData3), .iMemResp(memResp3), .iMemRData(memRData3),
    .oMemRead(memRead3), .oMemWrite(memWrite3), .oMemAddr(memAddr3), .oMemWData(memWData3),
    .oResp(resp3), .oRData(rData3), .oGrant(grant3)
  );

  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic void push2(input int cl, input logic [15:0] a, input logic wr, input logic [127:0] wd);
    exp_t x;
    x.resp = 3'(1 << cl); x.addr = a; x.wr = wr; x.wdata = wd;
    q2.push_back(x);
  endfunction

  function automatic void push3(input int cl, input logic [15:0] a);
    exp_t x;
    x.resp = 3'(1 << cl); x.addr = a; x.wr = 1'b0; x.wdata = '0;
    q3.push_back(x);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory models: answer a held strobe after LAT cycles with a one-cycle strobe.
  initial begin
    autoResp2 = 1'b0; cnt2 = 0;
    forever begin
      tick();
      if (autoResp2) begin autoResp2 = 1'b0; cnt2 = 0; end
      else if (autoEn2 && (memRead2 || memWrite2)) begin
        cnt2++;
        if (cnt2 == LAT) autoResp2 = 1'b1;
      end else cnt2 = 0;
    end
  end

  initial begin
    autoResp3 = 1'b0; cnt3 = 0;
    forever begin
      tick();
      if (autoResp3) begin autoResp3 = 1'b0; cnt3 = 0; end
      else if (memRead3 || memWrite3) begin
        cnt3++;
        if (cnt3 == LAT) autoResp3 = 1'b1;
      end else cnt3 = 0;
    end
  end

  // Scoreboard monitors
  always @(negedge clk) begin
    if (resp2 !== 2'b00) begin
      if (q2.size() == 0) chk("resp2_unexpected", 128'(resp2), 128'd0);
      else begin
        e2 = q2.pop_front();
        chk("resp2_client", 128'(resp2), 128'(e2.resp[1:0]));
        chk("resp2_addr", 128'(memAddr2), 128'(e2.addr));
        chk("resp2_write", 128'(memWrite2), 128'(e2.wr));
        chk("resp2_read", 128'(memRead2), 128'(!e2.wr));
        if (e2.wr) chk("resp2_wdata", memWData2, e2.wdata);
        else       chk("resp2_rdata", rData2, rdataOf(e2.addr));
      end
    end
  end

  always @(negedge clk) begin
    if (resp3 !== 3'b000) begin
      if (q3.size() == 0) chk("resp3_unexpected", 128'(resp3), 128'd0);
      else begin
        e3 = q3.pop_front();
        chk("resp3_client", 128'(resp3), 128'(e3.resp));
        chk("resp3_addr", 128'(memAddr3), 128'(e3.addr));
        chk("resp3_rdata", rData3, rdataOf(e3.addr));
      end
    end
  end

  // Run dut2 until nWant responses; optionally each client releases on its response.
  task automatic run2(input int nWant, input bit dropOnResp, input string tag);
    int got = 0;
    logic [1:0] dm = '0;
    for (int c = 0; c < 100 && got < nWant; c++) begin
      tick();
      if (dropOnResp) begin
        reqRead2  = reqRead2 & ~dm;
        reqWrite2 = reqWrite2 & ~dm;
      end
      dm = '0;
      @(negedge clk);
      if (resp2 !== 2'b00) begin got++; dm = resp2; end
    end
    tick();
    reqRead2 = '0; reqWrite2 = '0;
    chk({tag, "_count"}, 128'(got), 128'(nWant));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit done4;
    int n3;
    logic [2:0] dm3;

    rst = 1'b1; manResp2 = 1'b0; autoEn2 = 1'b1;
    reqRead2 = '0; reqWrite2 = '0; reqAddr2 = '0; reqWData2 = '0;
    reqRead3 = '0; reqWrite3 = '0; reqAddr3 = '0; reqWData3 = '0;

    // Reset state
    @(negedge clk);
    chk("rst_grant2", 128'(grant2), 128'd0);
    chk("rst_read2", 128'(memRead2), 128'd0);
    chk("rst_write2", 128'(memWrite2), 128'd0);
    chk("rst_addr2", 128'(memAddr2), 128'd0);
    chk("rst_wdata2", memWData2, 128'd0);
    chk("rst_grant3", 128'(grant3), 128'd0);
    tick(); rst = 1'b0;

    // T1: single read, latency and DONE/IDLE tail
    reqRead2 = 2'b01; reqAddr2[15:0] = 16'h1230;
    push2(0, 16'h1230, 1'b0, '0);
    tick();
    @(negedge clk);
    chk("t1_read", 128'(memRead2), 128'd1);
    chk("t1_write", 128'(memWrite2), 128'd0);
    chk("t1_addr", 128'(memAddr2), 128'h1230);
    chk("t1_grant", 128'(grant2), 128'b01);
    run2(1, 1'b1, "t1");
    @(negedge clk);
    chk("t1_done_read", 128'(memRead2), 128'd0);
    chk("t1_done_grant", 128'(grant2), 128'd0);
    tick();
    @(negedge clk);
    chk("t1_idle_grant", 128'(grant2), 128'd0);

    // T2: both clients read continuously from a reset pointer
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    reqRead2 = 2'b11; reqAddr2 = {16'h2000, 16'h1000};
    push2(0, 16'h1000, 1'b0, '0); push2(1, 16'h2000, 1'b0, '0);
    push2(0, 16'h1000, 1'b0, '0); push2(1, 16'h2000, 1'b0, '0);
    run2(4, 1'b0, "t2");

    // T4: client 1 write; its inputs change mid-transaction
    tick();
    reqWrite2 = 2'b10; reqAddr2[31:16] = 16'hBEEE; reqWData2[255:128] = {16{8'hA5}};
    push2(1, 16'hBEEE, 1'b1, {16{8'hA5}});
    tick();
    reqAddr2[31:16] = 16'h1111; reqWData2[255:128] = {16{8'h5A}};
    done4 = 1'b0;
    for (int c = 0; c < 10 && !done4; c++) begin
      @(negedge clk);
      chk("t4_addr", 128'(memAddr2), 128'hBEEE);
      chk("t4_wdata", memWData2, {16{8'hA5}});
      chk("t4_write", 128'(memWrite2), 128'd1);
      chk("t4_read", 128'(memRead2), 128'd0);
      if (resp2[1]) done4 = 1'b1;
      else tick();
    end
    chk("t4_done", 128'(done4), 128'd1);
    tick(); reqWrite2 = '0;

    // T5: memory strobe in IDLE and in DONE is ignored
    autoEn2 = 1'b0;
    tick(); manResp2 = 1'b1;
    @(negedge clk);
    chk("t5_idle_resp", 128'(resp2), 128'd0);
    chk("t5_idle_grant", 128'(grant2), 128'd0);
    tick(); manResp2 = 1'b0;
    @(negedge clk);
    chk("t5_idle_read", 128'(memRead2), 128'd0);
    chk("t5_idle_grant2", 128'(grant2), 128'd0);
    tick();
    reqRead2 = 2'b01; reqAddr2[15:0] = 16'h3330;
    push2(0, 16'h3330, 1'b0, '0);
    tick();
    tick(); manResp2 = 1'b1;
    tick(); reqRead2 = '0;
    @(negedge clk);
    chk("t5_done_resp", 128'(resp2), 128'd0);
    chk("t5_done_grant", 128'(grant2), 128'd0);
    chk("t5_done_read", 128'(memRead2), 128'd0);
    tick(); manResp2 = 1'b0;
    @(negedge clk);
    chk("t5_after_grant", 128'(grant2), 128'd0);
    chk("t5_after_read", 128'(memRead2), 128'd0);
    autoEn2 = 1'b1;

    // T6: asynchronous reset in the middle of a transaction
    tick();
    reqRead2 = 2'b01; reqAddr2[15:0] = 16'h4440;
    tick();
    @(negedge clk);
    chk("t6_busy_read", 128'(memRead2), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_read", 128'(memRead2), 128'd0);
    chk("t6_rst_write", 128'(memWrite2), 128'd0);
    chk("t6_rst_grant", 128'(grant2), 128'd0);
    chk("t6_rst_resp", 128'(resp2), 128'd0);
    reqRead2 = '0;
    tick(); tick(); rst = 1'b0;
    reqRead2 = 2'b11; reqAddr2 = {16'h6660, 16'h5550};
    push2(0, 16'h5550, 1'b0, '0); push2(1, 16'h6660, 1'b0, '0);
    run2(2, 1'b1, "t6");

    // T3: fixed priority, client 0 arrives while client 1 is being served
    tick();
    reqRead3 = 3'b110; reqAddr3 = {16'h0200, 16'h0100, 16'h0050};
    push3(1, 16'h0100); push3(0, 16'h0050); push3(2, 16'h0200);
    n3 = 0; dm3 = '0;
    for (int c = 0; c < 100 && n3 < 3; c++) begin
      tick();
      reqRead3 = reqRead3 & ~dm3;
      dm3 = '0;
      if (c == 0) reqRead3[0] = 1'b1;
      @(negedge clk);
      if (resp3 !== 3'b000) begin n3++; dm3 = resp3; end
    end
    tick(); reqRead3 = '0;
    chk("t3_count", 128'(n3), 128'd3);

    repeat (4) tick();
    chk("q2_drained", 128'(q2.size()), 128'd0);
    chk("q3_drained", 128'(q3.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
